i2c_bit_engine: RTL and testbench
=================================

Name: i2c_bit_engine

Overview:
- Byte-level I2C master engine sitting directly downstream of the team's divided-clock generator. That generator produces a square wave at 4x the target SCL rate.
- This block synchronizes the square wave, edge-detects it into quarter-bit ticks, and executes START/WRITE/READ/STOP commands on open-drain SCL/SDA.
- It feeds the MPU6050 transaction sequencer above it.

Parameters:
SYNC_STAGES, 2, number of flops synchronizing div_clk into the clock_in domain (legal 2..4)

Ports:
clock_in  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
div_clk  input  1  square wave from the clock divider, 4x SCL frequency; treated as asynchronous data
cmd_valid  input  1  command request
cmd  input  2  0=START, 1=WRITE, 2=READ, 3=STOP
wr_data  input  8  byte for WRITE; sampled on accept
rd_nack  input  1  READ only: 1 = master sends NACK after the byte; sampled on accept
cmd_ready  output  1  high only in IDLE; accept = cmd_valid & cmd_ready
done  output  1  one-cycle pulse at command completion
ack_rx  output  1  WRITE: 1 if slave pulled SDA low at ACK sample; valid with done; held until next done
rx_data  output  8  READ result, MSB first; valid with done; held until next done
cmd_err  output  1  valid with done; 1 = illegal command for current bus state
bus_owned  output  1  high from completed START until completed STOP
scl_oe  output  1  1 = drive SCL low; 0 = release
sda_oe  output  1  1 = drive SDA low; 0 = release
sda_in  input  1  SDA pad level; sampled directly, no extra synchronizer

Behaviour:
- Reset (async assert, sync release): scl_oe=0, sda_oe=0, cmd_ready=1, done=0, ack_rx=0, rx_data=0, cmd_err=0, bus_owned=0. Synchronizer and edge registers clear; state=IDLE.
  - Reset mid-command releases both lines immediately with no STOP generated.
- Tick: div_clk passes through SYNC_STAGES flops, then one edge register. tick = 1-cycle pulse on each synchronized rising edge, i.e. SYNC_STAGES+1 clock_in cycles after the raw edge.
  - Each bit period is 4 ticks, phases q0..q3. Outputs change only on tick cycles.
- States: IDLE, START, WBIT, RBIT, STOP. Bit counter 0..8, where 8 is the ACK slot.
- Accept in IDLE:
  - Latch cmd/wr_data/rd_nack, deassert cmd_ready next cycle.
  - Execution begins at the first tick after accept.
- Illegal commands: WRITE, READ or STOP with bus_owned=0.
  - No bus activity.
  - done with cmd_err=1 on the cycle after accept; return to IDLE.
- START, bus not owned: q0 no change (both released), q1 sda_oe=1, q2 hold, q3 scl_oe=1.
- START, bus owned (repeated START): q0 scl_oe=1 and sda_oe=0, q1 scl_oe=0, q2 sda_oe=1, q3 scl_oe=1.
- START completion: done on the q3 tick cycle; bus_owned=1 at the same time.
- Data/ACK bit, applies to WBIT and RBIT:
  - q0: scl_oe=1; sda_oe set from the bit to send.
  - q1: scl_oe=0.
  - q2: sample sda_in.
  - q3: scl_oe=1.
- WBIT:
  - Bits 0-7 send wr_data[7] first; sda_oe = ~bit.
  - Slot 8: sda_oe=0; ack_rx = ~sda_in sampled at q2.
- RBIT:
  - Bits 0-7: sda_oe=0; shift sda_in into rx_data LSB at q2.
  - Slot 8: sda_oe = ~rd_nack.
  - rx_data register updates only at completion; the shift register is internal.
- WRITE/READ completion: done on the slot-8 q3 tick. SCL is then held low and sda_oe keeps its last value until the next command.
- STOP:
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0.
  - q2: sda_oe=0.
  - q3: done, bus_owned=0.
- cmd_ready returns high the cycle after done. Back-to-back command acceptance on that cycle is legal.
- No clock stretching and no arbitration; SCL level is not sensed.
- cmd_valid while busy is ignored; the requester must hold it until accepted.
- div_clk stopped mid-command: the FSM freezes in its phase, and the outputs hold.

Test Plan:
- START, WRITE 0xD0, slave model drives ACK (SDA low at q2 of slot 8) -> SDA sequence during SCL high = 1,1,0,1,0,0,0,0. Then done with ack_rx=1 and cmd_err=0. SCL low after done; bus_owned=1.
- WRITE 0x3B with slave releasing SDA on ACK -> done, ack_rx=0. The bench then issues STOP -> SDA rises while SCL is high, and bus_owned=0.
- Repeated START then READ rd_nack=1, slave returns 0x68 (WHO_AM_I) -> rx_data=0x68, SDA released in slot 8. SCL falls then rises exactly 9 times.
- WRITE issued with bus_owned=0 -> done plus cmd_err=1 one cycle after accept; scl_oe/sda_oe never assert.
- Latency: raw div_clk rising edge with SYNC_STAGES=2 -> first output change on cycle 3 after the edge. Vary the div_clk duty cycle and phase relative to clock_in -> exactly one tick per rising edge.
- Assert reset_n low at bit 4 of a WRITE -> scl_oe=0 and sda_oe=0 in the same cycle (async); after release, cmd_ready=1 and bus_owned=0.

Source files
------------

// File: rtl/i2c_bit_engine.sv
// Byte-level I2C master: turns a 4x-SCL square wave into quarter-bit ticks and runs START/WRITE/READ/STOP.
// Outputs move SYNC_STAGES+1 cycles after a raw div_clk rise; one command at a time, cmd_ready only when idle.
module i2c_bit_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       div_clk,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic       cmd_ready,
    output logic       done,
    output logic       ack_rx,
    output logic [7:0] rx_data,
    output logic       cmd_err,
    output logic       bus_owned,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WBIT, S_RBIT, S_STOP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [1:0]              r_phase, w_phase_nxt;
    logic [3:0]              r_bit, w_bit_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_edge;
    logic                    w_tick;
    logic                    w_accept;

    logic [7:0] r_shift, w_shift_nxt;
    logic       r_nack, w_nack_nxt;
    logic       r_rep, w_rep_nxt;
    logic       r_ack_smp, w_ack_smp_nxt;
    logic       r_scl_oe, w_scl_oe_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_done, w_done_nxt;
    logic       r_ack, w_ack_nxt;
    logic [7:0] r_rx, w_rx_nxt;
    logic       r_err, w_err_nxt;
    logic       r_owned, w_owned_nxt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], div_clk};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick   = r_sync[SYNC_STAGES-1] & ~r_edge;
    assign w_accept = cmd_valid & cmd_ready;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_phase <= 2'd0;
            r_bit   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_phase_nxt = 2'd0;
                    w_bit_nxt   = 4'd0;
                    case (cmd)
                        CMD_START: w_state_nxt = S_START;
                        CMD_WRITE: w_state_nxt = r_owned ? S_WBIT : S_IDLE;
                        CMD_READ:  w_state_nxt = r_owned ? S_RBIT : S_IDLE;
                        CMD_STOP:  w_state_nxt = r_owned ? S_STOP : S_IDLE;
                    endcase
                end
            end
            S_START, S_STOP: begin
                if (w_tick) begin
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == 2'd3) w_state_nxt = S_IDLE;
                end
            end
            S_WBIT, S_RBIT: begin
                if (w_tick) begin
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        if (r_bit == 4'd8) w_state_nxt = S_IDLE;
                        else               w_bit_nxt   = r_bit + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next values; every bus-visible change is gated by a tick except the illegal-command reply.
    always_comb begin
        w_shift_nxt   = r_shift;
        w_nack_nxt    = r_nack;
        w_rep_nxt     = r_rep;
        w_ack_smp_nxt = r_ack_smp;
        w_scl_oe_nxt  = r_scl_oe;
        w_sda_oe_nxt  = r_sda_oe;
        w_done_nxt    = 1'b0;
        w_ack_nxt     = r_ack;
        w_rx_nxt      = r_rx;
        w_err_nxt     = r_err;
        w_owned_nxt   = r_owned;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = wr_data;
                    w_nack_nxt  = rd_nack;
                    w_rep_nxt   = r_owned;
                    if (cmd != CMD_START && !r_owned) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end
            end
            S_START: begin
                if (w_tick) begin
                    case (r_phase)
                        2'd0: if (r_rep) begin
                                  w_scl_oe_nxt = 1'b1;
                                  w_sda_oe_nxt = 1'b0;
                              end
                        2'd1: if (r_rep) w_scl_oe_nxt = 1'b0;
                              else       w_sda_oe_nxt = 1'b1;
                        2'd2: if (r_rep) w_sda_oe_nxt = 1'b1;
                        2'd3: begin
                            w_scl_oe_nxt = 1'b1;
                            w_done_nxt   = 1'b1;
                            w_owned_nxt  = 1'b1;
                            w_err_nxt    = 1'b0;
                        end
                    endcase
                end
            end
            S_WBIT: begin
                if (w_tick) begin
                    case (r_phase)
                        2'd0: begin
                            w_scl_oe_nxt = 1'b1;
                            w_sda_oe_nxt = (r_bit == 4'd8) ? 1'b0 : ~r_shift[7];
                        end
                        2'd1: w_scl_oe_nxt = 1'b0;
                        2'd2: if (r_bit == 4'd8) w_ack_smp_nxt = ~sda_in;
                        2'd3: begin
                            w_scl_oe_nxt = 1'b1;
                            if (r_bit == 4'd8) begin
                                w_done_nxt = 1'b1;
                                w_ack_nxt  = r_ack_smp;
                                w_err_nxt  = 1'b0;
                            end else begin
                                w_shift_nxt = {r_shift[6:0], 1'b0};
                            end
                        end
                    endcase
                end
            end
            S_RBIT: begin
                if (w_tick) begin
                    case (r_phase)
                        2'd0: begin
                            w_scl_oe_nxt = 1'b1;
                            w_sda_oe_nxt = (r_bit == 4'd8) ? ~r_nack : 1'b0;
                        end
                        2'd1: w_scl_oe_nxt = 1'b0;
                        2'd2: if (r_bit != 4'd8) w_shift_nxt = {r_shift[6:0], sda_in};
                        2'd3: begin
                            w_scl_oe_nxt = 1'b1;
                            if (r_bit == 4'd8) begin
                                w_done_nxt = 1'b1;
                                w_rx_nxt   = r_shift;
                                w_err_nxt  = 1'b0;
                            end
                        end
                    endcase
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    case (r_phase)
                        2'd0: begin
                            w_scl_oe_nxt = 1'b1;
                            w_sda_oe_nxt = 1'b1;
                        end
                        2'd1: w_scl_oe_nxt = 1'b0;
                        2'd2: w_sda_oe_nxt = 1'b0;
                        2'd3: begin
                            w_done_nxt  = 1'b1;
                            w_owned_nxt = 1'b0;
                            w_err_nxt   = 1'b0;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= 8'd0;
            r_nack    <= 1'b0;
            r_rep     <= 1'b0;
            r_ack_smp <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_rx      <= 8'd0;
            r_err     <= 1'b0;
            r_owned   <= 1'b0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_nack    <= w_nack_nxt;
            r_rep     <= w_rep_nxt;
            r_ack_smp <= w_ack_smp_nxt;
            r_scl_oe  <= w_scl_oe_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_done    <= w_done_nxt;
            r_ack     <= w_ack_nxt;
            r_rx      <= w_rx_nxt;
            r_err     <= w_err_nxt;
            r_owned   <= w_owned_nxt;
        end
    end

    // Held low during the done cycle so a new command is taken only once results are published.
    assign cmd_ready = (r_state == S_IDLE) && !r_done;
    assign done      = r_done;
    assign ack_rx    = r_ack;
    assign rx_data   = r_rx;
    assign cmd_err   = r_err;
    assign bus_owned = r_owned;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed bench for i2c_bit_engine with a small I2C slave model and bus-condition monitor.
`timescale 1ns/1ps
module tb_i2c_bit_engine;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       div_clk;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       rd_nack;
    logic       cmd_ready;
    logic       done;
    logic       ack_rx;
    logic [7:0] rx_data;
    logic       cmd_err;
    logic       bus_owned;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;

    logic       slave_pull;
    int         slave_mode = 0;
    logic [7:0] slave_byte = 8'h00;
    int         rel;

    int         fall_cnt = 0, rise_cnt = 0, fall_base = 0;
    int         done_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0;
    logic [15:0] hist = 16'h0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       w_scl, w_sda;

    int tests = 0;
    int fails = 0;

    i2c_bit_engine #(.SYNC_STAGES(2)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .div_clk   (div_clk),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_nack   (rd_nack),
        .cmd_ready (cmd_ready),
        .done      (done),
        .ack_rx    (ack_rx),
        .rx_data   (rx_data),
        .cmd_err   (cmd_err),
        .bus_owned (bus_owned),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    always #5 clock_in = ~clock_in;

    // Slave: changes SDA only after SCL falls, indexed by falls since the command was issued.
    always_comb begin
        rel = fall_cnt - fall_base;
        slave_pull = 1'b0;
        if (slave_mode == 2 && rel >= 0 && rel < 8)
            slave_pull = ~slave_byte[3'(7 - rel)];
        else if (slave_mode == 1 && rel == 8)
            slave_pull = 1'b1;
    end

    assign w_scl  = ~scl_oe;
    assign w_sda  = ~(sda_oe | slave_pull);
    assign sda_in = w_sda;

    always @(negedge clock_in) begin
        if (prev_scl && !w_scl) fall_cnt <= fall_cnt + 1;
        if (!prev_scl && w_scl) begin
            rise_cnt <= rise_cnt + 1;
            hist     <= {hist[14:0], w_sda};
        end
        if (prev_scl && w_scl && prev_sda && !w_sda) start_cnt <= start_cnt + 1;
        if (prev_scl && w_scl && !prev_sda && w_sda) stop_cnt <= stop_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (scl_oe || sda_oe) oe_cnt <= oe_cnt + 1;
        prev_scl <= w_scl;
        prev_sda <= w_sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic n);
        int budget;
        fall_base = fall_cnt;
        @(negedge clock_in);
        cmd_valid = 1'b1;
        cmd       = c;
        wr_data   = d;
        rd_nack   = n;
        budget    = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge clock_in);
            budget++;
        end
        if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clock_in);
        #1 cmd_valid = 1'b0;
    endtask

    // n rising edges of div_clk; vary=1 changes high/low widths and phase against clock_in.
    task automatic div_edges(input int n, input bit vary);
        int hi, lo, ph;
        for (int i = 0; i < n; i++) begin
            hi = vary ? 1 + (i % 3) : 2;
            lo = vary ? 1 + ((i + 1) % 3) : 2;
            ph = vary ? 1 + 3 * (i % 3) : 2;
            @(posedge clock_in);
            #(ph) div_clk = 1'b1;
            repeat (hi) @(posedge clock_in);
            #(ph) div_clk = 1'b0;
            repeat (lo) @(posedge clock_in);
        end
        repeat (4) @(posedge clock_in);
    endtask

    initial begin
        int d, s, r, f, p, o;
        reset_n   = 1'b0;
        div_clk   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        wr_data   = 8'd0;
        rd_nack   = 1'b0;

        repeat (3) @(negedge clock_in);
        check("reset_flags", 32'({scl_oe, sda_oe, cmd_ready, done, ack_rx, cmd_err, bus_owned}), 32'b0010000);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clock_in);

        // WRITE with the bus not owned
        o = oe_cnt; d = done_cnt;
        issue(2'd1, 8'h55, 1'b0);
        @(negedge clock_in);
        check("illegal_done", 32'(done), 32'd1);
        check("illegal_err", 32'(cmd_err), 32'd1);
        check("illegal_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clock_in);
        check("illegal_done_pulse", 32'(done), 32'd0);
        check("illegal_ready_back", 32'(cmd_ready), 32'd1);
        div_edges(8, 1'b0);
        check("illegal_no_oe", 32'(oe_cnt), 32'(o));
        check("illegal_done_once", 32'(done_cnt), 32'(d + 1));
        check("illegal_not_owned", 32'(bus_owned), 32'd0);

        // START with tick latency measurement on q1
        s = start_cnt; d = done_cnt;
        issue(2'd0, 8'h00, 1'b0);
        div_edges(1, 1'b0);
        check("start_q0_quiet", 32'({scl_oe, sda_oe}), 32'd0);
        @(negedge clock_in); div_clk = 1'b1;
        @(negedge clock_in);
        check("lat_cycle1", 32'(sda_oe), 32'd0);
        @(negedge clock_in);
        check("lat_cycle2", 32'(sda_oe), 32'd0);
        @(negedge clock_in);
        check("lat_cycle3", 32'(sda_oe), 32'd1);
        div_clk = 1'b0;
        repeat (3) @(negedge clock_in);
        div_edges(2, 1'b0);
        check("start_done", 32'(done_cnt), 32'(d + 1));
        check("start_owned", 32'(bus_owned), 32'd1);
        check("start_lines", 32'({scl_oe, sda_oe}), 32'b11);
        check("start_cond", 32'(start_cnt), 32'(s + 1));
        check("start_err", 32'(cmd_err), 32'd0);

        // WRITE 0xD0, slave ACKs
        r = rise_cnt; d = done_cnt;
        issue(2'd1, 8'hD0, 1'b0);
        slave_mode = 1;
        div_edges(36, 1'b0);
        slave_mode = 0;
        check("wd0_done", 32'(done_cnt), 32'(d + 1));
        check("wd0_sda_bits", 32'(hist[8:0]), 32'h1A0);
        check("wd0_ack", 32'(ack_rx), 32'd1);
        check("wd0_err", 32'(cmd_err), 32'd0);
        check("wd0_scl_low", 32'(scl_oe), 32'd1);
        check("wd0_owned", 32'(bus_owned), 32'd1);
        check("wd0_rises", 32'(rise_cnt), 32'(r + 9));

        // WRITE 0x3B, no ACK, irregular div_clk: done exactly on the 36th edge
        d = done_cnt;
        issue(2'd1, 8'h3B, 1'b0);
        div_edges(35, 1'b1);
        check("w3b_not_early", 32'(done_cnt), 32'(d));
        div_edges(1, 1'b1);
        check("w3b_done", 32'(done_cnt), 32'(d + 1));
        check("w3b_nack", 32'(ack_rx), 32'd0);
        check("w3b_sda_bits", 32'(hist[8:0]), 32'h077);

        // STOP
        p = stop_cnt; d = done_cnt;
        issue(2'd3, 8'h00, 1'b0);
        div_edges(4, 1'b0);
        check("stop_cond", 32'(stop_cnt), 32'(p + 1));
        check("stop_done", 32'(done_cnt), 32'(d + 1));
        check("stop_not_owned", 32'(bus_owned), 32'd0);
        check("stop_lines", 32'({scl_oe, sda_oe}), 32'd0);
        check("stop_err", 32'(cmd_err), 32'd0);

        // START, repeated START, READ with NACK
        issue(2'd0, 8'h00, 1'b0);
        div_edges(4, 1'b0);
        s = start_cnt;
        issue(2'd0, 8'h00, 1'b0);
        div_edges(4, 1'b0);
        check("rstart_cond", 32'(start_cnt), 32'(s + 1));
        check("rstart_owned", 32'(bus_owned), 32'd1);
        r = rise_cnt; f = fall_cnt;
        issue(2'd2, 8'h00, 1'b1);
        slave_byte = 8'h68;
        slave_mode = 2;
        div_edges(36, 1'b0);
        slave_mode = 0;
        check("read_rx", 32'(rx_data), 32'h68);
        check("read_err", 32'(cmd_err), 32'd0);
        check("read_rises", 32'(rise_cnt), 32'(r + 9));
        check("read_falls", 32'(fall_cnt), 32'(f + 9));
        check("read_nack_released", 32'(sda_oe), 32'd0);
        check("read_line_bits", 32'(hist[8:0]), 32'h0D1);

        // Reset during bit 4 of a WRITE
        issue(2'd1, 8'hA5, 1'b0);
        div_edges(17, 1'b0);
        check("rst_pre_lines", 32'({scl_oe, sda_oe}), 32'b11);
        p = stop_cnt;
        @(negedge clock_in);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_lines", 32'({scl_oe, sda_oe}), 32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (2) @(negedge clock_in);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_not_owned", 32'(bus_owned), 32'd0);
        check("rst_no_stop", 32'(stop_cnt), 32'(p));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
